// File: rtl/cache_pkg.sv
// Shared geometry, types and FSM encoding for the set-associative cache.
// Every cache file imports this package so widths stay consistent.
package cache_pkg;

    localparam int unsigned NumSets       = 16;
    localparam int unsigned TagWidth      = 8;
    localparam int unsigned Associativity = 4;
    localparam int unsigned DataWidth     = 16;

    localparam int unsigned SetWidth  = $clog2(NumSets);
    localparam int unsigned WayWidth  = (Associativity > 1) ? $clog2(Associativity) : 1;
    localparam int unsigned AddrWidth = TagWidth + SetWidth;

    typedef logic [DataWidth-1:0] block_data_t;

    typedef struct packed {
        logic                valid;
        logic [TagWidth-1:0] tag;
    } block_info_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LOOKUP   = 2'd1,
        MEM_REQ  = 2'd2,
        MEM_WAIT = 2'd3
    } cache_state_e;

    typedef struct packed {
        logic                 we;
        logic [AddrWidth-1:0] addr;
        block_data_t          wdata;
    } cache_req_t;

    function automatic logic [SetWidth-1:0] addr_set(input logic [AddrWidth-1:0] addr);
        return addr[SetWidth-1:0];
    endfunction

    function automatic logic [TagWidth-1:0] addr_tag(input logic [AddrWidth-1:0] addr);
        return addr[AddrWidth-1:SetWidth];
    endfunction

endpackage

// File: rtl/sa_cache_if.sv
// Requester and memory-side signals of the cache, bundled with modports.
// Handshakes: a transfer happens on a rising edge where valid and ready are both 1; a
// source holding valid keeps its payload stable until that edge. rsp_valid and
// mem_rsp_valid are single-cycle pulses with no ready.
interface sa_cache_if;
    import cache_pkg::*;

    logic                 flush_i;
    logic                 req_valid_i;
    logic                 req_ready_o;
    logic                 req_we_i;
    logic [AddrWidth-1:0] req_addr_i;
    block_data_t          req_wdata_i;
    logic                 rsp_valid_o;
    block_data_t          rsp_rdata_o;
    logic                 rsp_hit_o;
    logic                 mem_req_valid_o;
    logic                 mem_req_ready_i;
    logic                 mem_req_we_o;
    logic [AddrWidth-1:0] mem_req_addr_o;
    block_data_t          mem_req_wdata_o;
    logic                 mem_rsp_valid_i;
    block_data_t          mem_rsp_rdata_i;

    modport slave (
        input  flush_i, req_valid_i, req_we_i, req_addr_i, req_wdata_i,
        input  mem_req_ready_i, mem_rsp_valid_i, mem_rsp_rdata_i,
        output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_hit_o,
        output mem_req_valid_o, mem_req_we_o, mem_req_addr_o, mem_req_wdata_o
    );

    modport master (
        output flush_i, req_valid_i, req_we_i, req_addr_i, req_wdata_i,
        output mem_req_ready_i, mem_rsp_valid_i, mem_rsp_rdata_i,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_hit_o,
        input  mem_req_valid_o, mem_req_we_o, mem_req_addr_o, mem_req_wdata_o
    );

endinterface

// File: rtl/cache_data_sram.sv
// Block data store: one write port, synchronous read of every way of one set.
// The read register only updates on rd_en_i so LOOKUP sees the set read in IDLE.
module cache_data_sram
    import cache_pkg::*;
(
    input  logic                              clk_i,
    input  logic                              rd_en_i,
    input  logic [SetWidth-1:0]               rd_set_i,
    output block_data_t [Associativity-1:0]   rd_data_o,
    input  logic                              wr_en_i,
    input  logic [SetWidth-1:0]               wr_set_i,
    input  logic [WayWidth-1:0]               wr_way_i,
    input  block_data_t                       wr_data_i
);

    block_data_t                     mem_q [NumSets][Associativity];
    block_data_t [Associativity-1:0] rd_data_q;

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_set_i][wr_way_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            for (int w = 0; w < Associativity; w++) begin
                rd_data_q[w] <= mem_q[rd_set_i][w];
            end
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/sa_cache.sv
// N-way set-associative write-through, no-write-allocate cache with per-set
// round-robin replacement and an invalidate-all flush.
module sa_cache
    import cache_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_ni,
    sa_cache_if.slave    bus,
    output cache_state_e state_o
);

    cache_state_e        state_q, state_d;
    cache_req_t          req_q, req_d;
    logic                hit_q, hit_d;
    logic                flush_pending_q, flush_pending_d;
    block_info_t         info_q [NumSets][Associativity];
    block_info_t         info_d [NumSets][Associativity];
    logic [WayWidth-1:0] rr_q [NumSets];
    logic [WayWidth-1:0] rr_d [NumSets];

    logic [SetWidth-1:0]             cur_set;
    logic [TagWidth-1:0]             cur_tag;
    logic                            hit, has_invalid, req_ready;
    logic [WayWidth-1:0]             hit_way, victim_way;
    block_data_t [Associativity-1:0] sram_rd;
    logic                            sram_rd_en, sram_we;
    logic [WayWidth-1:0]             sram_wr_way;
    block_data_t                     sram_wr_data;
    logic                            rsp_valid, rsp_hit, mem_valid;
    block_data_t                     rsp_rdata;

    assign cur_set   = addr_set(req_q.addr);
    assign cur_tag   = addr_tag(req_q.addr);
    assign req_ready = rst_ni && (state_q == IDLE) && !bus.flush_i && !flush_pending_q;

    // Lowest matching way wins; victim is lowest invalid way, else the set's pointer.
    always_comb begin
        hit         = 1'b0;
        hit_way     = '0;
        has_invalid = 1'b0;
        victim_way  = rr_q[cur_set];
        for (int w = 0; w < Associativity; w++) begin
            if (!hit && info_q[cur_set][w].valid && info_q[cur_set][w].tag == cur_tag) begin
                hit     = 1'b1;
                hit_way = WayWidth'(w);
            end
            if (!has_invalid && !info_q[cur_set][w].valid) begin
                has_invalid = 1'b1;
                victim_way  = WayWidth'(w);
            end
        end
    end

    always_comb begin
        state_d         = state_q;
        req_d           = req_q;
        hit_d           = hit_q;
        flush_pending_d = flush_pending_q;
        info_d          = info_q;
        rr_d            = rr_q;
        sram_rd_en      = 1'b0;
        sram_we         = 1'b0;
        sram_wr_way     = hit_way;
        sram_wr_data    = req_q.wdata;
        rsp_valid       = 1'b0;
        rsp_hit         = 1'b0;
        rsp_rdata       = '0;

        if (state_q != IDLE && bus.flush_i) begin
            flush_pending_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (bus.flush_i || flush_pending_q) begin
                    flush_pending_d = 1'b0;
                    for (int s = 0; s < NumSets; s++) begin
                        for (int w = 0; w < Associativity; w++) begin
                            info_d[s][w].valid = 1'b0;
                        end
                    end
                end else if (bus.req_valid_i && req_ready) begin
                    req_d      = '{we: bus.req_we_i, addr: bus.req_addr_i, wdata: bus.req_wdata_i};
                    sram_rd_en = 1'b1;
                    state_d    = LOOKUP;
                end
            end
            LOOKUP: begin
                hit_d = hit;
                if (!req_q.we && hit) begin
                    rsp_valid = 1'b1;
                    rsp_hit   = 1'b1;
                    rsp_rdata = sram_rd[hit_way];
                    state_d   = IDLE;
                end else begin
                    sram_we = req_q.we && hit;
                    state_d = MEM_REQ;
                end
            end
            MEM_REQ: begin
                if (bus.mem_req_ready_i) begin
                    state_d = MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                // Writes park here for exactly one cycle to deliver their response.
                if (req_q.we) begin
                    rsp_valid = 1'b1;
                    rsp_hit   = hit_q;
                    state_d   = IDLE;
                end else if (bus.mem_rsp_valid_i) begin
                    sram_we                    = 1'b1;
                    sram_wr_way                = victim_way;
                    sram_wr_data               = bus.mem_rsp_rdata_i;
                    info_d[cur_set][victim_way] = '{valid: 1'b1, tag: cur_tag};
                    if (!has_invalid) begin
                        rr_d[cur_set] = (rr_q[cur_set] == WayWidth'(Associativity - 1)) ?
                                        '0 : rr_q[cur_set] + WayWidth'(1);
                    end
                    rsp_valid = 1'b1;
                    rsp_rdata = bus.mem_rsp_rdata_i;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q         <= IDLE;
            req_q           <= '0;
            hit_q           <= 1'b0;
            flush_pending_q <= 1'b0;
            for (int s = 0; s < NumSets; s++) begin
                rr_q[s] <= '0;
                for (int w = 0; w < Associativity; w++) begin
                    info_q[s][w] <= '0;
                end
            end
        end else begin
            state_q         <= state_d;
            req_q           <= req_d;
            hit_q           <= hit_d;
            flush_pending_q <= flush_pending_d;
            info_q          <= info_d;
            rr_q            <= rr_d;
        end
    end

    cache_data_sram u_data_sram (
        .clk_i     (clk_i),
        .rd_en_i   (sram_rd_en),
        .rd_set_i  (addr_set(bus.req_addr_i)),
        .rd_data_o (sram_rd),
        .wr_en_i   (sram_we && rst_ni),
        .wr_set_i  (cur_set),
        .wr_way_i  (sram_wr_way),
        .wr_data_i (sram_wr_data)
    );

    assign mem_valid           = rst_ni && (state_q == MEM_REQ);
    assign bus.req_ready_o     = req_ready;
    assign bus.rsp_valid_o     = rst_ni && rsp_valid;
    assign bus.rsp_hit_o       = rst_ni && rsp_hit;
    assign bus.rsp_rdata_o     = rst_ni ? rsp_rdata : '0;
    assign bus.mem_req_valid_o = mem_valid;
    assign bus.mem_req_we_o    = mem_valid && req_q.we;
    assign bus.mem_req_addr_o  = mem_valid ? req_q.addr : '0;
    assign bus.mem_req_wdata_o = mem_valid ? req_q.wdata : '0;
    assign state_o             = state_q;

endmodule

// File: tb/tb_sa_cache.sv
// Directed bench for sa_cache: misses, hits, replacement, write policy,
// memory back-pressure, pending flush and reset mid-transaction.
module tb_sa_cache;
  import cache_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  cache_state_e state;
  int checks = 0;
  int errors = 0;

  sa_cache_if bus ();

  sa_cache dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .bus     (bus),
    .state_o (state)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present a request and complete its handshake; returns settled in the T+1 cycle.
  task automatic issue(input logic we, input logic [11:0] addr, input logic [15:0] wd);
    int n = 0;
    bus.req_valid_i = 1'b1;
    bus.req_we_i    = we;
    bus.req_addr_i  = addr;
    bus.req_wdata_i = wd;
    #1;
    while (!bus.req_ready_o && n < 20) begin
      cyc();
      n++;
    end
    chk("req_ready_before_handshake", 32'(bus.req_ready_o), 32'd1);
    cyc();
    bus.req_valid_i = 1'b0;
    #1;
  endtask

  task automatic read_hit(input logic [11:0] addr, input logic [15:0] exp);
    issue(1'b0, addr, 16'h0);
    chk("hit_rsp_valid", 32'(bus.rsp_valid_o), 32'd1);
    chk("hit_rsp_hit", 32'(bus.rsp_hit_o), 32'd1);
    chk("hit_rdata", 32'(bus.rsp_rdata_o), 32'(exp));
    chk("hit_no_mem_req", 32'(bus.mem_req_valid_o), 32'd0);
    cyc();
    chk("hit_back_idle", 32'(bus.req_ready_o), 32'd1);
  endtask

  task automatic read_miss(input logic [11:0] addr, input logic [15:0] mdata);
    issue(1'b0, addr, 16'h0);
    chk("miss_no_rsp_lookup", 32'(bus.rsp_valid_o), 32'd0);
    cyc();
    chk("miss_mem_valid", 32'(bus.mem_req_valid_o), 32'd1);
    chk("miss_mem_we", 32'(bus.mem_req_we_o), 32'd0);
    chk("miss_mem_addr", 32'(bus.mem_req_addr_o), 32'(addr));
    bus.mem_req_ready_i = 1'b1;
    cyc();
    bus.mem_req_ready_i = 1'b0;
    bus.mem_rsp_valid_i = 1'b1;
    bus.mem_rsp_rdata_i = mdata;
    #1;
    chk("miss_mem_valid_dropped", 32'(bus.mem_req_valid_o), 32'd0);
    chk("miss_rsp_valid", 32'(bus.rsp_valid_o), 32'd1);
    chk("miss_rsp_hit", 32'(bus.rsp_hit_o), 32'd0);
    chk("miss_rdata", 32'(bus.rsp_rdata_o), 32'(mdata));
    cyc();
    bus.mem_rsp_valid_i = 1'b0;
    #1;
    chk("miss_rsp_single_pulse", 32'(bus.rsp_valid_o), 32'd0);
  endtask

  task automatic write_req(input logic [11:0] addr, input logic [15:0] wd, input logic exp_hit);
    issue(1'b1, addr, wd);
    chk("wr_no_rsp_lookup", 32'(bus.rsp_valid_o), 32'd0);
    cyc();
    chk("wr_mem_valid", 32'(bus.mem_req_valid_o), 32'd1);
    chk("wr_mem_we", 32'(bus.mem_req_we_o), 32'd1);
    chk("wr_mem_addr", 32'(bus.mem_req_addr_o), 32'(addr));
    chk("wr_mem_wdata", 32'(bus.mem_req_wdata_o), 32'(wd));
    bus.mem_req_ready_i = 1'b1;
    cyc();
    bus.mem_req_ready_i = 1'b0;
    #1;
    chk("wr_rsp_valid", 32'(bus.rsp_valid_o), 32'd1);
    chk("wr_rsp_hit", 32'(bus.rsp_hit_o), 32'(exp_hit));
    cyc();
    chk("wr_rsp_single_pulse", 32'(bus.rsp_valid_o), 32'd0);
  endtask

  initial begin
    bus.flush_i         = 1'b0;
    bus.req_valid_i     = 1'b0;
    bus.req_we_i        = 1'b0;
    bus.req_addr_i      = '0;
    bus.req_wdata_i     = '0;
    bus.mem_req_ready_i = 1'b0;
    bus.mem_rsp_valid_i = 1'b0;
    bus.mem_rsp_rdata_i = '0;

    // Reset state
    cyc();
    cyc();
    chk("rst_state", 32'(state), 32'(IDLE));
    chk("rst_req_ready", 32'(bus.req_ready_o), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
    chk("rst_mem_valid", 32'(bus.mem_req_valid_o), 32'd0);
    chk("rst_rdata", 32'(bus.rsp_rdata_o), 32'd0);
    rst_n = 1'b1;
    cyc();
    chk("post_rst_ready", 32'(bus.req_ready_o), 32'd1);
    bus.flush_i = 1'b1;
    #1;
    chk("flush_blocks_ready", 32'(bus.req_ready_o), 32'd0);
    cyc();
    bus.flush_i = 1'b0;
    #1;
    chk("ready_after_flush", 32'(bus.req_ready_o), 32'd1);

    // 1: cold miss then hit
    read_miss(12'h015, 16'hBEEF);
    read_hit(12'h015, 16'hBEEF);

    // 2: replacement in set 5 (0x015 already in way 0)
    read_miss(12'h025, 16'h2525);
    read_miss(12'h035, 16'h3535);
    read_miss(12'h045, 16'h4545);
    read_miss(12'h055, 16'h5555);   // evicts way 0 (0x015), pointer -> 1
    read_hit(12'h025, 16'h2525);
    read_hit(12'h055, 16'h5555);
    read_miss(12'h015, 16'h1515);   // evicts way 1 (0x025), pointer -> 2
    read_miss(12'h025, 16'h2626);   // evicts way 2 (0x035), pointer -> 3
    read_hit(12'h045, 16'h4545);

    // 3: write policy
    write_req(12'h025, 16'h1234, 1'b1);
    read_hit(12'h025, 16'h1234);
    write_req(12'h0A7, 16'h00A7, 1'b0);
    read_miss(12'h0A7, 16'h7A7A);

    // 4: memory back-pressure
    issue(1'b0, 12'h0B7, 16'h0);
    cyc();
    for (int i = 0; i < 5; i++) begin
      chk("bp_mem_valid", 32'(bus.mem_req_valid_o), 32'd1);
      chk("bp_mem_addr", 32'(bus.mem_req_addr_o), 32'h0B7);
      chk("bp_mem_we", 32'(bus.mem_req_we_o), 32'd0);
      chk("bp_req_ready", 32'(bus.req_ready_o), 32'd0);
      cyc();
    end
    bus.mem_req_ready_i = 1'b1;
    #1;
    chk("bp_mem_valid_at_hs", 32'(bus.mem_req_valid_o), 32'd1);
    cyc();
    chk("bp_single_handshake", 32'(bus.mem_req_valid_o), 32'd0);
    cyc();
    bus.mem_req_ready_i = 1'b0;
    chk("bp_still_waiting", 32'(state), 32'(MEM_WAIT));
    bus.mem_rsp_valid_i = 1'b1;
    bus.mem_rsp_rdata_i = 16'hB7B7;
    #1;
    chk("bp_rsp_valid", 32'(bus.rsp_valid_o), 32'd1);
    chk("bp_rdata", 32'(bus.rsp_rdata_o), 32'hB7B7);
    cyc();
    bus.mem_rsp_valid_i = 1'b0;
    read_hit(12'h0B7, 16'hB7B7);

    // 5: flush raised during MEM_WAIT
    issue(1'b0, 12'h097, 16'h0);
    cyc();
    bus.mem_req_ready_i = 1'b1;
    cyc();
    bus.mem_req_ready_i = 1'b0;
    bus.flush_i = 1'b1;
    #1;
    chk("pf_no_rsp_yet", 32'(bus.rsp_valid_o), 32'd0);
    cyc();
    bus.flush_i = 1'b0;
    bus.mem_rsp_valid_i = 1'b1;
    bus.mem_rsp_rdata_i = 16'h9999;
    #1;
    chk("pf_rsp_valid", 32'(bus.rsp_valid_o), 32'd1);
    chk("pf_rdata", 32'(bus.rsp_rdata_o), 32'h9999);
    cyc();
    bus.mem_rsp_valid_i = 1'b0;
    #1;
    chk("pf_idle", 32'(state), 32'(IDLE));
    chk("pf_ready_low", 32'(bus.req_ready_o), 32'd0);
    cyc();
    chk("pf_ready_back", 32'(bus.req_ready_o), 32'd1);
    read_miss(12'h097, 16'h9797);
    read_miss(12'h025, 16'h2727);
    read_miss(12'h0B7, 16'hB8B8);

    // 6: reset during MEM_WAIT, then a stray memory response
    read_miss(12'h037, 16'h3737);
    read_hit(12'h037, 16'h3737);
    issue(1'b0, 12'h015, 16'h0);
    cyc();
    bus.mem_req_ready_i = 1'b1;
    cyc();
    bus.mem_req_ready_i = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mr_rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
    chk("mr_mem_valid", 32'(bus.mem_req_valid_o), 32'd0);
    chk("mr_req_ready", 32'(bus.req_ready_o), 32'd0);
    cyc();
    cyc();
    chk("mr_state", 32'(state), 32'(IDLE));
    chk("mr_ready_held", 32'(bus.req_ready_o), 32'd0);
    rst_n = 1'b1;
    cyc();
    bus.mem_rsp_valid_i = 1'b1;
    bus.mem_rsp_rdata_i = 16'hDEAD;
    #1;
    chk("stray_no_rsp", 32'(bus.rsp_valid_o), 32'd0);
    cyc();
    bus.mem_rsp_valid_i = 1'b0;
    chk("stray_state", 32'(state), 32'(IDLE));
    read_miss(12'h037, 16'h3838);
    read_miss(12'h015, 16'h1616);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
